// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU: default widths, opcodes and FSM states.
// Build option: ACC_CPU_ILLEGAL_TRAP_EN enables trapping of undefined opcodes.
package acc_cpu_pkg;

  localparam int ADDR_W_DEFAULT = 12;
  localparam int DATA_W_DEFAULT = 16;

  localparam logic [3:0] OP_CLA = 4'h0;
  localparam logic [3:0] OP_COM = 4'h1;
  localparam logic [3:0] OP_SHR = 4'h2;
  localparam logic [3:0] OP_CSL = 4'h3;
  localparam logic [3:0] OP_STP = 4'h4;
  localparam logic [3:0] OP_ADD = 4'h5;
  localparam logic [3:0] OP_STA = 4'h6;
  localparam logic [3:0] OP_LDA = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_BAN = 4'h9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  // Opcodes above OP_BAN have no defined behaviour.
  function automatic logic is_defined_op(input logic [3:0] op);
    return (op <= OP_BAN);
  endfunction

endpackage

// File: rtl/acc_cpu_ctrl_if.sv
// Instruction-fetch and data-memory bus between the CPU (master) and its memories (slave).
// Both memories are read combinationally from the addresses presented here.
interface acc_cpu_ctrl_if
  import acc_cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
);
  logic [ADDR_W-1:0] insAd;
  logic [DATA_W-1:0] ins;
  logic [ADDR_W-1:0] datAd;
  logic [DATA_W-1:0] datRd;
  logic [DATA_W-1:0] datWr;
  logic              datWe;

  modport master (
    output insAd,
    output datAd,
    output datWr,
    output datWe,
    input  ins,
    input  datRd
  );

  modport slave (
    input  insAd,
    input  datAd,
    input  datWr,
    input  datWe,
    output ins,
    output datRd
  );
endinterface

// File: rtl/acc_cpu_alu.sv
// Combinational accumulator datapath: computes the next ACC for the executing opcode.
// Opcodes that do not touch ACC (including undefined ones) pass it through unchanged.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic [3:0]        opcode,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] dat_rd,
  output logic [DATA_W-1:0] acc_next
);

  always_comb begin
    acc_next = acc;
    case (opcode)
      OP_CLA:  acc_next = '0;
      OP_COM:  acc_next = ~acc;
      OP_SHR:  acc_next = {acc[DATA_W-1], acc[DATA_W-1:1]};
      OP_CSL:  acc_next = {acc[DATA_W-2:0], acc[DATA_W-1]};
      OP_ADD:  acc_next = acc + dat_rd;
      OP_LDA:  acc_next = dat_rd;
      default: acc_next = acc;
    endcase
  end

endmodule

// File: rtl/acc_cpu_ctrl.sv
// Two-cycle (FETCH/EXEC) accumulator CPU controller holding PC, CPC, IR, ACC and the FSM.
// Build option: ACC_CPU_ILLEGAL_TRAP_EN makes undefined opcodes set 'illegal' and halt.
module acc_cpu_ctrl
  import acc_cpu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  acc_cpu_ctrl_if.master    bus,
  output logic [DATA_W-1:0] acc,
  output logic              halted,
  output logic              illegal
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [ADDR_W-1:0] cpc_reg, cpc_next;
  logic [DATA_W-1:0] ir_reg, ir_next;
  logic [DATA_W-1:0] acc_reg, acc_next;
  logic [DATA_W-1:0] alu_acc;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [ADDR_W-1:0] dat_ad;
  logic              dat_we;
`ifdef ACC_CPU_ILLEGAL_TRAP_EN
  logic              illegal_reg, illegal_next;
`endif

  assign opcode  = ir_reg[DATA_W-1 -: 4];
  assign operand = ir_reg[ADDR_W-1:0];

  acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .opcode   (opcode),
    .acc      (acc_reg),
    .dat_rd   (bus.datRd),
    .acc_next (alu_acc)
  );

  // Asynchronous reset also kills an in-flight STA strobe, since datWe decodes from state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      pc_reg    <= '0;
      cpc_reg   <= '0;
      ir_reg    <= '0;
      acc_reg   <= '0;
`ifdef ACC_CPU_ILLEGAL_TRAP_EN
      illegal_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      cpc_reg   <= cpc_next;
      ir_reg    <= ir_next;
      acc_reg   <= acc_next;
`ifdef ACC_CPU_ILLEGAL_TRAP_EN
      illegal_reg <= illegal_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    cpc_next   = cpc_reg;
    ir_next    = ir_reg;
    acc_next   = acc_reg;
    dat_ad     = '0;
    dat_we     = 1'b0;
`ifdef ACC_CPU_ILLEGAL_TRAP_EN
    illegal_next = illegal_reg;
`endif
    unique case (state_reg)
      ST_IDLE: begin
        pc_next = '0;
        if (start) state_next = ST_FETCH;
      end
      ST_FETCH: begin
        ir_next    = bus.ins;
        cpc_next   = pc_reg;
        pc_next    = pc_reg + ADDR_W'(1);
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        dat_ad     = operand;
        acc_next   = alu_acc;
        state_next = ST_FETCH;
        case (opcode)
          OP_STP: state_next = ST_HALT;
          OP_STA: dat_we = 1'b1;
          OP_JMP: pc_next = operand;
          // Branch is relative to the instruction's own address, not the already-advanced PC.
          OP_BAN: if (acc_reg[DATA_W-1]) pc_next = cpc_reg + operand;
          default: begin
`ifdef ACC_CPU_ILLEGAL_TRAP_EN
            if (!is_defined_op(opcode)) begin
              illegal_next = 1'b1;
              acc_next     = acc_reg;
              state_next   = ST_HALT;
            end
`endif
          end
        endcase
      end
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_IDLE;
    endcase
  end

  assign bus.insAd = pc_reg;
  assign bus.datAd = dat_ad;
  assign bus.datWr = acc_reg;
  assign bus.datWe = dat_we;
  assign acc       = acc_reg;
  assign halted    = (state_reg == ST_HALT);
`ifdef ACC_CPU_ILLEGAL_TRAP_EN
  assign illegal   = illegal_reg;
`else
  assign illegal   = 1'b0;
`endif

endmodule

// File: tb/tb_acc_cpu_ctrl.sv
// Directed testbench for acc_cpu_ctrl: sample program, ALU corner cases, PC wrap,
// reset during a store, undefined opcode (ACC_CPU_ILLEGAL_TRAP_EN aware) and idle hold.
module tb_acc_cpu_ctrl;

  logic clk;
  logic rst_n;
  logic start;
  logic [15:0] acc;
  logic halted;
  logic illegal;

  int checks = 0;
  int errors = 0;

  logic [15:0] imem [0:4095];
  logic [15:0] dmem [0:4095];
  logic        ld_we;
  logic [11:0] ld_addr;
  logic [15:0] ld_data;

  acc_cpu_ctrl_if #(.ADDR_W(12), .DATA_W(16)) bus ();

  acc_cpu_ctrl #(.ADDR_W(12), .DATA_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bus     (bus),
    .acc     (acc),
    .halted  (halted),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.ins   = imem[bus.insAd];
  assign bus.datRd = dmem[bus.datAd];

  // Data memory has a single writer: the CPU store strobe, or the bench preload port.
  always @(posedge clk) begin
    if (bus.datWe) dmem[bus.datAd] <= bus.datWr;
    else if (ld_we) dmem[ld_addr] <= ld_data;
  end

  function automatic logic [15:0] enc(input logic [3:0] op, input logic [11:0] opd);
    return {op, opd};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [15:0] d);
    ld_addr = a;
    ld_data = d;
    ld_we   = 1'b1;
    @(negedge clk);
    ld_we   = 1'b0;
  endtask

  task automatic reset_hold();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 4096; i++) imem[i] = 16'h0000;
  endtask

  // Release reset with start high; returns at the negedge where the CPU sits in FETCH of address 0.
  task automatic launch();
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One instruction: check the store strobe mid-EXEC, then ACC and next fetch address.
  task automatic step(input string tag, input logic exp_we, input logic [15:0] exp_acc,
                      input logic [11:0] exp_pc);
    @(negedge clk);
    check({tag, ".datWe"}, 32'(bus.datWe), 32'(exp_we));
    @(negedge clk);
    check({tag, ".acc"}, 32'(acc), 32'(exp_acc));
    check({tag, ".insAd"}, 32'(bus.insAd), 32'(exp_pc));
    check({tag, ".datAd"}, 32'(bus.datAd), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    ld_we   = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    for (int i = 0; i < 4096; i++) imem[i] = 16'h0000;

    // ---------------- sample program, with idle-hold before start
    imem[0]  = enc(4'h7, 12'd0);
    imem[1]  = enc(4'h3, 12'd0);
    imem[2]  = enc(4'h9, 12'd10);
    imem[3]  = enc(4'h1, 12'd0);
    imem[4]  = enc(4'h2, 12'd0);
    imem[5]  = enc(4'h9, 12'd2);
    imem[7]  = enc(4'h8, 12'd9);
    imem[9]  = enc(4'h5, 12'd1);
    imem[10] = enc(4'h6, 12'd0);
    imem[11] = enc(4'h7, 12'd1);
    imem[12] = enc(4'h0, 12'd0);
    imem[13] = enc(4'h4, 12'd0);
    imem[14] = enc(4'h6, 12'd1);
    @(negedge clk);
    poke(12'd0, 16'd1);
    poke(12'd1, 16'd2);
    check("rst.acc", 32'(acc), 32'd0);
    check("rst.insAd", 32'(bus.insAd), 32'd0);
    check("rst.datWe", 32'(bus.datWe), 32'd0);
    check("rst.halted", 32'(halted), 32'd0);
    check("rst.illegal", 32'(illegal), 32'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle.insAd", 32'(bus.insAd), 32'd0);
      check("idle.datWe", 32'(bus.datWe), 32'd0);
      check("idle.acc", 32'(acc), 32'd0);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("prog.fetch0", 32'(bus.insAd), 32'd0);
    step("prog.lda0", 1'b0, 16'h0001, 12'd1);
    step("prog.csl", 1'b0, 16'h0002, 12'd2);
    step("prog.ban10", 1'b0, 16'h0002, 12'd3);
    step("prog.com", 1'b0, 16'hFFFD, 12'd4);
    step("prog.shr", 1'b0, 16'hFFFE, 12'd5);
    step("prog.ban2", 1'b0, 16'hFFFE, 12'd7);
    step("prog.jmp9", 1'b0, 16'hFFFE, 12'd9);
    step("prog.add1", 1'b0, 16'h0000, 12'd10);
    step("prog.sta0", 1'b1, 16'h0000, 12'd11);
    step("prog.lda1", 1'b0, 16'h0002, 12'd12);
    step("prog.cla", 1'b0, 16'h0000, 12'd13);
    step("prog.stp", 1'b0, 16'h0000, 12'd14);
    check("prog.halted", 32'(halted), 32'd1);
    check("prog.mem0", 32'(dmem[0]), 32'h0000);
    check("prog.mem1", 32'(dmem[1]), 32'h0002);
    repeat (4) @(negedge clk);
    check("halt.acc", 32'(acc), 32'd0);
    check("halt.insAd", 32'(bus.insAd), 32'd14);
    check("halt.datWe", 32'(bus.datWe), 32'd0);
    check("halt.halted", 32'(halted), 32'd1);
    check("halt.mem1", 32'(dmem[1]), 32'h0002);
    $display("txn: sample program done, acc=0x%0h", acc);

    // ---------------- rotate / arithmetic shift corner values
    reset_hold();
    imem[0] = enc(4'h7, 12'd0);
    imem[1] = enc(4'h3, 12'd0);
    imem[2] = enc(4'h7, 12'd1);
    imem[3] = enc(4'h2, 12'd0);
    imem[4] = enc(4'h4, 12'd0);
    poke(12'd0, 16'h8001);
    poke(12'd1, 16'h8000);
    launch();
    step("shift.lda", 1'b0, 16'h8001, 12'd1);
    step("shift.csl", 1'b0, 16'h0003, 12'd2);
    step("shift.lda2", 1'b0, 16'h8000, 12'd3);
    step("shift.shr", 1'b0, 16'hC000, 12'd4);
    step("shift.stp", 1'b0, 16'hC000, 12'd5);
    check("shift.halted", 32'(halted), 32'd1);
    $display("txn: shift corners done, acc=0x%0h", acc);

    // ---------------- ADD wrap and PC wrap at top of memory
    reset_hold();
    imem[0]    = enc(4'h7, 12'd0);
    imem[1]    = enc(4'h5, 12'd1);
    imem[2]    = enc(4'h8, 12'hFFF);
    imem[4095] = enc(4'h1, 12'd0);
    poke(12'd0, 16'hFFFF);
    poke(12'd1, 16'h0002);
    launch();
    step("wrap.lda", 1'b0, 16'hFFFF, 12'd1);
    step("wrap.add", 1'b0, 16'h0001, 12'd2);
    step("wrap.jmp", 1'b0, 16'h0001, 12'hFFF);
    step("wrap.com", 1'b0, 16'hFFFE, 12'h000);
    check("wrap.halted", 32'(halted), 32'd0);
    $display("txn: wrap checks done, insAd=0x%0h", bus.insAd);

    // ---------------- asynchronous reset in the middle of a store
    reset_hold();
    imem[0] = enc(4'h7, 12'd0);
    imem[1] = enc(4'h6, 12'd1);
    poke(12'd0, 16'h1234);
    poke(12'd1, 16'h5555);
    launch();
    step("rstsa.lda", 1'b0, 16'h1234, 12'd1);
    @(negedge clk);
    check("rstsa.we_before", 32'(bus.datWe), 32'd1);
    check("rstsa.datAd", 32'(bus.datAd), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstsa.we_after", 32'(bus.datWe), 32'd0);
    check("rstsa.acc", 32'(acc), 32'd0);
    check("rstsa.insAd", 32'(bus.insAd), 32'd0);
    @(negedge clk);
    check("rstsa.mem1", 32'(dmem[1]), 32'h5555);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rstsa.idle_insAd", 32'(bus.insAd), 32'd0);
    check("rstsa.idle_acc", 32'(acc), 32'd0);
    check("rstsa.idle_halted", 32'(halted), 32'd0);
    $display("txn: reset during STA done, mem1=0x%0h", dmem[1]);

    // ---------------- undefined opcode 1111 at address 0
    reset_hold();
    imem[0] = enc(4'hF, 12'd0);
    imem[1] = enc(4'h4, 12'd0);
    launch();
    repeat (2) @(negedge clk);
`ifdef ACC_CPU_ILLEGAL_TRAP_EN
    check("ill.illegal", 32'(illegal), 32'd1);
    check("ill.halted", 32'(halted), 32'd1);
    check("ill.acc", 32'(acc), 32'd0);
    check("ill.insAd", 32'(bus.insAd), 32'd1);
`else
    check("ill.illegal", 32'(illegal), 32'd0);
    check("ill.halted", 32'(halted), 32'd0);
    check("ill.acc", 32'(acc), 32'd0);
    check("ill.insAd", 32'(bus.insAd), 32'd1);
    step("ill.stp", 1'b0, 16'h0000, 12'd2);
    check("ill.halted_after_stp", 32'(halted), 32'd1);
    check("ill.illegal_after_stp", 32'(illegal), 32'd0);
`endif
    $display("txn: undefined opcode done, illegal=%0b halted=%0b", illegal, halted);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
